// File: rtl/alu_pkg.sv
// Shared types and helpers for the ALU result stage.
package alu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned TRACE_W = XLEN + 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD_SUB = 4'd0,
    ALU_SLL     = 4'd1,
    ALU_SR      = 4'd2,
    ALU_SLT     = 4'd3,
    ALU_SLTU    = 4'd4,
    ALU_XOR     = 4'd5,
    ALU_OR      = 4'd6,
    ALU_AND     = 4'd7,
    ALU_BEQ     = 4'd8,
    ALU_BNE     = 4'd9,
    ALU_BLT     = 4'd10,
    ALU_BGE     = 4'd11,
    ALU_BLTU    = 4'd12,
    ALU_BGEU    = 4'd13
  } alu_op_e;

  // Selected result for one op: writeback value plus compare/branch bit.
  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            cmp;
  } stage_res_t;

  // Trace tag for branch results in the upper nibble.
  localparam logic [TRACE_W-1:0] TRACE_BRANCH = {4'b0001, 32'b0};

  // Ops whose result depends on the compare flags.
  function automatic logic is_cmp(alu_op_e op);
    return op inside {ALU_SLT, ALU_SLTU, ALU_BEQ, ALU_BNE,
                      ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
  endfunction

  // Branch ops write back zero and only produce a condition.
  function automatic logic is_branch(alu_op_e op);
    return op inside {ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Issue-side and writeback-side signals of the ALU result stage.
interface alu_result_stage_if;
  import alu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  alu_op_e             alu_op;
  logic [XLEN-1:0]     reg_op1;
  logic [XLEN-1:0]     reg_op2;
  logic [XLEN-1:0]     alu_add_sub;
  logic [XLEN-1:0]     alu_shl;
  logic [XLEN-1:0]     alu_shr;
  logic                alu_eq;
  logic                alu_ltu;
  logic                alu_lts;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_data;
  logic                out_cmp;
  logic                trace_valid;
  logic [TRACE_W-1:0]  trace_data;

  modport master (
    output in_valid, alu_op, reg_op1, reg_op2, alu_add_sub, alu_shl, alu_shr,
           alu_eq, alu_ltu, alu_lts, out_ready,
    input  in_ready, out_valid, out_data, out_cmp, trace_valid, trace_data
  );

  modport slave (
    input  in_valid, alu_op, reg_op1, reg_op2, alu_add_sub, alu_shl, alu_shr,
           alu_eq, alu_ltu, alu_lts, out_ready,
    output in_ready, out_valid, out_data, out_cmp, trace_valid, trace_data
  );

endinterface

// File: rtl/alu_cond_sel.sv
// Combinational op -> {data, cmp} selection from ALU results and operands.
module alu_cond_sel
  import alu_pkg::*;
(
  input  alu_op_e         op,
  input  logic [XLEN-1:0] reg_op1,
  input  logic [XLEN-1:0] reg_op2,
  input  logic [XLEN-1:0] alu_add_sub,
  input  logic [XLEN-1:0] alu_shl,
  input  logic [XLEN-1:0] alu_shr,
  input  logic            alu_eq,
  input  logic            alu_ltu,
  input  logic            alu_lts,
  output stage_res_t      res_c
);

  // Result mux; unknown codes yield zero data and no condition.
  always_comb begin
    res_c = '0;
    case (op)
      ALU_ADD_SUB: res_c.data = alu_add_sub;
      ALU_SLL:     res_c.data = alu_shl;
      ALU_SR:      res_c.data = alu_shr;
      ALU_SLT:     begin res_c.data = XLEN'(alu_lts); res_c.cmp = alu_lts; end
      ALU_SLTU:    begin res_c.data = XLEN'(alu_ltu); res_c.cmp = alu_ltu; end
      ALU_XOR:     res_c.data = reg_op1 ^ reg_op2;
      ALU_OR:      res_c.data = reg_op1 | reg_op2;
      ALU_AND:     res_c.data = reg_op1 & reg_op2;
      ALU_BEQ:     res_c.cmp  = alu_eq;
      ALU_BNE:     res_c.cmp  = !alu_eq;
      ALU_BLT:     res_c.cmp  = alu_lts;
      ALU_BGE:     res_c.cmp  = !alu_lts;
      ALU_BLTU:    res_c.cmp  = alu_ltu;
      ALU_BGEU:    res_c.cmp  = !alu_ltu;
      default:     res_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: latency wait FSM plus one-entry registered writeback slot.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter bit TWO_CYCLE_ALU     = 1'b0,
  parameter bit TWO_CYCLE_COMPARE = 1'b0,
  parameter bit ENABLE_TRACE      = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic flush,
  alu_result_stage_if.slave bus
);

  typedef enum logic [0:0] {ST_IDLE, ST_WAIT} state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] lat;
  logic       cmp_q;
  logic       cap_cmp;
  logic       cmp_reg_en;
  logic       load;
  logic       slot_free;
  logic       handshake;
  logic       br_q;
  stage_res_t sel_c;
  stage_res_t res_c;

  alu_cond_sel u_cond_sel (
    .op          (bus.alu_op),
    .reg_op1     (bus.reg_op1),
    .reg_op2     (bus.reg_op2),
    .alu_add_sub (bus.alu_add_sub),
    .alu_shl     (bus.alu_shl),
    .alu_shr     (bus.alu_shr),
    .alu_eq      (bus.alu_eq),
    .alu_ltu     (bus.alu_ltu),
    .alu_lts     (bus.alu_lts),
    .res_c       (sel_c)
  );

  assign cmp_reg_en   = TWO_CYCLE_COMPARE && is_cmp(bus.alu_op);
  assign lat          = 2'(TWO_CYCLE_ALU) + 2'(cmp_reg_en);
  assign slot_free    = !bus.out_valid || bus.out_ready;
  assign handshake    = bus.out_valid && bus.out_ready;
  assign bus.in_ready = load;

  // Registered-compare ops take their condition from cmp_q instead of the live flags.
  always_comb begin
    res_c = sel_c;
    if (cmp_reg_en) begin
      res_c.cmp  = cmp_q;
      res_c.data = is_branch(bus.alu_op) ? '0 : XLEN'(cmp_q);
    end
  end

  // Next-state logic; flush overrides everything and suppresses the load.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    cap_cmp = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            if (lat == 2'd0) begin
              load = slot_free;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = lat;
              cap_cmp = (lat == 2'd1) && cmp_reg_en;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q > 2'd1) begin
            cnt_d   = cnt_q - 2'd1;
            cap_cmp = (cnt_q == 2'd2) && cmp_reg_en;
          end else if (slot_free) begin
            load    = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // FSM state, wait counter and captured compare condition.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      cmp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap_cmp) cmp_q <= sel_c.cmp;
    end
  end

  // Output slot: load wins over drain, so drain+load keeps out_valid high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_cmp   <= 1'b0;
      br_q          <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= res_c.data;
      bus.out_cmp   <= res_c.cmp;
      br_q          <= is_branch(bus.alu_op);
    end else if (handshake) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Trace pulse one cycle after each writeback handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.trace_valid <= 1'b0;
      bus.trace_data  <= '0;
    end else if (ENABLE_TRACE) begin
      bus.trace_valid <= handshake;
      if (handshake) bus.trace_data <= (br_q ? TRACE_BRANCH : '0) | TRACE_W'(bus.out_data);
    end
  end

endmodule
